// File: rtl/rf_ctrl_pkg.sv
// Shared types and sizing for the register-file write-back controller.
// Imported by the interface, the result FIFO and the arbiter top.
package rf_ctrl_pkg;
  localparam int XLEN     = 32;
  localparam int NREG     = 32;
  localparam int AW       = 5;
  localparam int LQ_DEPTH = 2;

  typedef logic [AW-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t        rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // x0 is hard-wired, so it can never be busy regardless of the vector
  function automatic logic idx_busy(logic [NREG-1:0] vec, reg_idx_t idx);
    return (idx != '0) && vec[idx];
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Decode, execute and register-file signals seen by the write-back arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline.
interface regfile_wb_arbiter_if;
  import rf_ctrl_pkg::*;

  logic            issue_valid;
  reg_idx_t        issue_rs1;
  reg_idx_t        issue_rs2;
  reg_idx_t        issue_rd;
  logic            issue_long;
  logic            issue_stall;
  logic            alu_valid;
  reg_idx_t        alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lu_valid;
  reg_idx_t        lu_rd;
  logic [XLEN-1:0] lu_data;
  logic            lu_ready;
  logic            rf_we;
  reg_idx_t        rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic [NREG-1:0] pending;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_long,
    output alu_valid, alu_rd, alu_data,
    output lu_valid, lu_rd, lu_data,
    input  issue_stall, lu_ready, rf_we, rf_rd, rf_wdata, pending
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_long,
    input  alu_valid, alu_rd, alu_data,
    input  lu_valid, lu_rd, lu_data,
    output issue_stall, lu_ready, rf_we, rf_rd, rf_wdata, pending
  );
endinterface

// File: rtl/wb_fifo.sv
// Small FIFO of pending long-unit write-back entries.
// Head is readable combinationally so the arbiter can pop and forward in one cycle.
module wb_fifo
  import rf_ctrl_pkg::*;
#(
  parameter int DEPTH = LQ_DEPTH
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW:0]     count_reg;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_reg == (PW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr_reg];

  // Storage carries no reset; only the pointers define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the ALU and the long-latency unit,
// and tracks outstanding long-unit writes to stall hazardous issues.
module regfile_wb_arbiter
  import rf_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);
  logic            rf_we_reg;
  reg_idx_t        rf_rd_reg;
  logic [XLEN-1:0] rf_wdata_reg;
  logic            rf_src_lu_reg;
  logic [NREG-1:0] pending_reg;
  logic [NREG-1:0] pending_next;

  wb_entry_t       fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic            alu_req;
  logic            issue_stall;
  logic            sb_set;
  logic            sb_clr;

  assign alu_req   = bus.alu_valid & (bus.alu_rd != '0);
  assign fifo_pop  = ~alu_req & ~fifo_empty;
  // x0 results are acknowledged but dropped here rather than queued
  assign fifo_push = bus.lu_valid & ~fifo_full & (bus.lu_rd != '0);

  wb_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ('{rd: bus.lu_rd, data: bus.lu_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign issue_stall = bus.issue_valid & (idx_busy(pending_reg, bus.issue_rs1) |
                                          idx_busy(pending_reg, bus.issue_rs2) |
                                          idx_busy(pending_reg, bus.issue_rd));
  assign sb_set = bus.issue_valid & ~issue_stall & bus.issue_long & (bus.issue_rd != '0);
  // Clear on the same edge the register file commits the long-unit value
  assign sb_clr = rf_we_reg & rf_src_lu_reg;

  assign pending_next[0] = 1'b0;
  for (genvar gi = 1; gi < NREG; gi++) begin : g_sb
    assign pending_next[gi] =
        (pending_reg[gi] & ~(sb_clr && (rf_rd_reg == reg_idx_t'(gi)))) |
        (sb_set && (bus.issue_rd == reg_idx_t'(gi)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we_reg     <= 1'b0;
      rf_rd_reg     <= '0;
      rf_wdata_reg  <= '0;
      rf_src_lu_reg <= 1'b0;
      pending_reg   <= '0;
    end else begin
      rf_we_reg     <= alu_req | fifo_pop;
      rf_src_lu_reg <= fifo_pop;
      pending_reg   <= pending_next;
      if (alu_req) begin
        rf_rd_reg    <= bus.alu_rd;
        rf_wdata_reg <= bus.alu_data;
      end else if (fifo_pop) begin
        rf_rd_reg    <= fifo_head.rd;
        rf_wdata_reg <= fifo_head.data;
      end
    end
  end

  assign bus.issue_stall = issue_stall;
  assign bus.lu_ready    = ~fifo_full;
  assign bus.rf_we       = rf_we_reg;
  assign bus.rf_rd       = rf_rd_reg;
  assign bus.rf_wdata    = rf_wdata_reg;
  assign bus.pending     = pending_reg;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized plus directed bench for regfile_wb_arbiter; expected register
// writes go to a queue that an independent monitor drains on every rf_we.
module tb_regfile_wb_arbiter;
  import rf_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  wb_entry_t       exp_q[$];     // register writes in the order the file must see them
  wb_entry_t       lq_model[$];  // queued long-unit results
  logic [NREG-1:0] pend_m;       // registers with an outstanding long write
  int              clr_now;      // long-unit write on rf_* this cycle (-1: none)
  wb_entry_t       mon_w;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.rf_we !== 1'b0) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got rf_rd=%0d rf_wdata=%h, expected no write",
                 bus.rf_rd, bus.rf_wdata);
      end else begin
        mon_w = exp_q.pop_front();
        check("wb_rd", 64'(bus.rf_rd), 64'(mon_w.rd));
        check("wb_data", 64'(bus.rf_wdata), 64'(mon_w.data));
      end
    end
  end

  // One clock cycle: drive inputs, check combinational outputs against the
  // model, then advance the model across the closing edge.
  task automatic step(input logic iv, input reg_idx_t rs1, input reg_idx_t rs2,
                      input reg_idx_t rd, input logic il,
                      input logic av, input reg_idx_t ard, input logic [XLEN-1:0] adata,
                      input logic lv, input reg_idx_t lrd, input logic [XLEN-1:0] ldata,
                      output logic stall_o, output logic lu_acc_o);
    logic exp_ready;
    int   next_clr;
    bus.issue_valid = iv;  bus.issue_rs1 = rs1; bus.issue_rs2 = rs2;
    bus.issue_rd = rd;     bus.issue_long = il;
    bus.alu_valid = av;    bus.alu_rd = ard;    bus.alu_data = adata;
    bus.lu_valid = lv;     bus.lu_rd = lrd;     bus.lu_data = ldata;
    stall_o = iv && ((rs1 != 0 && pend_m[rs1]) || (rs2 != 0 && pend_m[rs2]) ||
                     (rd != 0 && pend_m[rd]));
    exp_ready = (lq_model.size() < LQ_DEPTH);
    #1;
    check("issue_stall", 64'(bus.issue_stall), 64'(stall_o));
    check("lu_ready", 64'(bus.lu_ready), 64'(exp_ready));
    check("pending", 64'(bus.pending), 64'(pend_m));
    lu_acc_o = lv && exp_ready;
    next_clr = -1;
    if (av && ard != 0) begin
      exp_q.push_back('{rd: ard, data: adata});
    end else if (lq_model.size() > 0) begin
      wb_entry_t w;
      w = lq_model.pop_front();
      exp_q.push_back(w);
      next_clr = int'(w.rd);
    end
    if (lu_acc_o && lrd != 0) lq_model.push_back('{rd: lrd, data: ldata});
    if (clr_now >= 0) pend_m[clr_now] = 1'b0;
    if (iv && !stall_o && il && rd != 0) pend_m[rd] = 1'b1;
    clr_now = next_clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic s, a;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, s, a);
  endtask

  initial begin
    logic s, a;
    logic hold_v, h_il;
    reg_idx_t h_rs1, h_rs2, h_rd;
    reg_idx_t outq[$];
    logic lv, av;
    reg_idx_t lrd, ard;

    pend_m  = '0;
    clr_now = -1;
    bus.issue_valid = 0; bus.issue_rs1 = 0; bus.issue_rs2 = 0; bus.issue_rd = 0;
    bus.issue_long = 0;  bus.alu_valid = 0; bus.alu_rd = 0;    bus.alu_data = 0;
    bus.lu_valid = 0;    bus.lu_rd = 0;     bus.lu_data = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);

    // ALU write lands one cycle later, then nothing
    step(0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, s, a);
    idle(3);

    // Long rd=7, dependent rs1=7 stalls until the result has been written
    step(1, 1, 2, 7, 1, 0, 0, 0, 0, 0, 0, s, a);
    for (int i = 0; i < 3; i++) step(1, 7, 0, 8, 0, 0, 0, 0, 0, 0, 0, s, a);
    step(1, 7, 0, 8, 0, 0, 0, 0, 1, 7, 32'h0000_0777, s, a);
    for (int i = 0; i < 6 && s; i++) step(1, 7, 0, 8, 0, 0, 0, 0, 0, 0, 0, s, a);
    check("dep_issued", 64'(s), 64'(0));
    idle(2);

    // ALU and long unit in the same cycle: ALU first
    step(0, 0, 0, 0, 0, 1, 3, 32'h11, 1, 9, 32'h22, s, a);
    idle(3);

    // ALU saturating the port fills the FIFO; a third push is refused
    step(0, 0, 0, 0, 0, 1, 1, 32'hA1, 1, 4, 32'h44, s, a);
    step(0, 0, 0, 0, 0, 1, 2, 32'hA2, 1, 6, 32'h66, s, a);
    step(0, 0, 0, 0, 0, 1, 3, 32'hA3, 1, 8, 32'h88, s, a);
    check("full_refuses", 64'(a), 64'(0));
    step(0, 0, 0, 0, 0, 1, 4, 32'hA4, 0, 0, 0, s, a);
    idle(4);

    // x0 handling
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, s, a);
    step(0, 0, 0, 0, 0, 1, 1, 32'hB1, 1, 10, 32'hAA, s, a);
    step(0, 0, 0, 0, 0, 1, 0, 32'hBAD0, 0, 0, 0, s, a);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hBAD1, s, a);
    check("x0_lu_accepted", 64'(a), 64'(1));
    step(1, 0, 0, 11, 1, 0, 0, 0, 0, 0, 0, s, a);
    step(1, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, s, a);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 11, 32'hBB, s, a);
    idle(4);

    // Reset mid-operation with two queued results and x7 pending
    step(1, 0, 0, 7, 1, 1, 1, 32'hC1, 1, 4, 32'h44, s, a);
    step(0, 0, 0, 0, 0, 1, 2, 32'hC2, 1, 6, 32'h66, s, a);
    bus.issue_valid = 0; bus.alu_valid = 0; bus.lu_valid = 0;
    reset = 1'b1;
    #1;
    check("rst_rf_we", 64'(bus.rf_we), 64'(0));
    check("rst_pending", 64'(bus.pending), 64'(0));
    check("rst_lu_ready", 64'(bus.lu_ready), 64'(1));
    exp_q.delete();
    lq_model.delete();
    pend_m  = '0;
    clr_now = -1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(4);
    check("post_rst_rf_we", 64'(bus.rf_we), 64'(0));

    // Randomized traffic with a behavioural long unit
    hold_v = 0; h_il = 0; h_rs1 = 0; h_rs2 = 0; h_rd = 0;
    for (int c = 0; c < 600; c++) begin
      if (!hold_v) begin
        hold_v = ($urandom % 2) == 1;
        h_rs1  = reg_idx_t'($urandom % NREG);
        h_rs2  = reg_idx_t'($urandom % NREG);
        h_rd   = reg_idx_t'($urandom % NREG);
        h_il   = ($urandom % 3) == 0;
      end
      lv = 0; lrd = 0;
      if (outq.size() > 0 && ($urandom % 2) == 1) begin
        lv = 1; lrd = outq[0];
      end else if (outq.size() == 0 && ($urandom % 8) == 0) begin
        lv = 1; lrd = 0;
      end
      av  = ($urandom % 2) == 1;
      ard = reg_idx_t'($urandom % NREG);
      step(hold_v, h_rs1, h_rs2, h_rd, h_il, av, ard, $urandom,
           lv, lrd, $urandom, s, a);
      if (a && lrd != 0) void'(outq.pop_front());
      if (hold_v && !s) begin
        if (h_il && h_rd != 0) outq.push_back(h_rd);
        hold_v = 0;
      end
    end

    // Drain the long unit and the FIFO
    for (int c = 0; c < 40; c++) begin
      lv  = outq.size() > 0;
      lrd = lv ? outq[0] : reg_idx_t'(0);
      step(0, 0, 0, 0, 0, 0, 0, 0, lv, lrd, $urandom, s, a);
      if (a && lv) void'(outq.pop_front());
    end
    idle(3);
    check("drain_pending", 64'(bus.pending), 64'(0));
    check("writes_missing", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-back controller for the 32x32 RISC-V register file. It shares the file's single write port between the single-cycle ALU path and a long-latency unit (load/MUL/DIV). It buffers long-unit results in a small FIFO and keeps a pending-write scoreboard that stalls issue on RAW/WAW hazards. It sits between execute/decode and the register file, driving its RegWrite, Rd and Write_data inputs.

Parameters:
XLEN, 32, data width
NREG, 32, number of architectural registers
AW, 5, register index width
LQ_DEPTH, 2, long-unit result FIFO depth (power of 2, >=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
issue_valid  in  1  decode presents an instruction
issue_rs1  in  AW  source 1 index
issue_rs2  in  AW  source 2 index
issue_rd  in  AW  destination index
issue_long  in  1  instruction targets the long-latency unit
issue_stall  out  1  combinational: instruction must not issue this cycle
alu_valid  in  1  ALU result valid; always accepted, cannot be back-pressured
alu_rd  in  AW  ALU destination
alu_data  in  XLEN  ALU result
lu_valid  in  1  long-unit result valid
lu_rd  in  AW  long-unit destination
lu_data  in  XLEN  long-unit result
lu_ready  out  1  combinational: FIFO not full
rf_we  out  1  registered: to register file RegWrite
rf_rd  out  AW  registered: to register file Rd
rf_wdata  out  XLEN  registered: to register file Write_data
pending  out  NREG  scoreboard vector, bit i = write to xi outstanding

Behaviour:
- Reset (async, immediate): rf_we=0, rf_rd=0, rf_wdata=0, pending=0, FIFO empty. lu_ready=1, including while reset is held. Reset mid-operation discards queued results and pending bits.
- x0: never marked pending. rs=0 and rd=0 never cause a stall. alu_rd=0 is treated as no ALU request. lu_valid with lu_rd=0 is accepted (ready permitting) and discarded, not enqueued.
- Stall: issue_stall = issue_valid & (pending[rs1] | pending[rs2] | pending[rd]), with x0 masked.
- Scoreboard set: at the edge where issue_valid & !issue_stall & issue_long & rd!=0, set pending[rd].
- Scoreboard clear: at the edge where rf_we & rf_src_lu (internal flag), clear pending[rf_rd]. This is the same edge at which the register file commits the value.
- Set and clear cannot target the same index in the same cycle, because the WAW stall prevents it.
- FIFO: push on lu_valid & lu_ready & lu_rd!=0. lu_ready = !full, so a full FIFO refuses a push even in a cycle that pops. Order is strict FIFO.
- Arbitration, evaluated each cycle:
  - ALU request (alu_valid & alu_rd!=0) has absolute priority: next rf_* = ALU fields, rf_src_lu=0.
  - Otherwise, if the FIFO is non-empty: pop the head, next rf_* = head, rf_src_lu=1.
  - Otherwise rf_we=0. rf_rd and rf_wdata hold their last value.
- Latency:
  - A result selected in cycle N appears on rf_* in cycle N+1.
  - The register file is written at the end of N+1.
  - The scoreboard bit clears at that same edge, so a dependent instruction issues in N+2 and reads the new value.
  - Push to pop latency is at least 1 cycle.
- Starvation: continuous ALU writes starve the FIFO. Pipeline bubbles guarantee drain, so no internal timeout.

Decomposition:
- Package rf_ctrl_pkg: XLEN, NREG, AW, LQ_DEPTH; typedef reg_idx_t (logic [AW-1:0]); struct wb_entry_t {reg_idx_t rd; logic [XLEN-1:0] data;}.
- Sub-module wb_fifo: generic LQ_DEPTH-entry FIFO of wb_entry_t with push/pop/full/empty and the same async active-high reset.
- Scoreboard, arbitration and output registers stay in the top module.

Test Plan:
- Assert reset with 2 entries queued and pending=0x0000_0080 -> immediately rf_we=0, pending=0, lu_ready=1. After release, nothing is written.
- alu_valid, alu_rd=5, alu_data=0xDEADBEEF in cycle t -> rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF in t+1. rf_we=0 in t+2 if idle.
- Issue long rd=7, then issue rs1=7 -> issue_stall=1 until lu_rd=7 is popped in N. issue_stall=0 in N+2, and pending[7] is 0 from N+2.
- Same cycle: alu(rd=3, 0x11) and lu(rd=9, 0x22) -> rf writes x3=0x11 in t+1, then x9=0x22 in t+2.
- Continuous ALU writes while lu pushes rd=4, then rd=6 -> lu_ready=0 after 2 pushes. When the ALU goes idle, x4 then x6 are written in order, and lu_ready returns to 1 after the first pop.
- x0 cases: issue_long rd=0 sets nothing; alu_rd=0 gives rf_we=0 and lets the FIFO drain that cycle; lu_rd=0 is accepted and never written. An issue with rs1=0 never stalls.
